ifetch_queue: RTL and testbench

Instruction fetch front end. Issues 64-byte line reads on the AXI read channels, splits each 64-bit beat into two 32-bit instructions and buffers them with their PCs. Delivers one instruction per cycle to the decode stage over a valid/ready handshake. Sits between the system bus and the decoder; the decoder drives redirects back into it.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/insn_fifo.sv | 68 ++++++
 rtl/ifetch_queue.sv | 164 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and AXI constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} fetch_state_e;

  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned LINE_SLOTS     = LINE_BYTES / 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(BEATS_PER_LINE - 1);
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } insn_t;

  function automatic logic [63:0] line_addr(input logic [63:0] pc);
    return pc & ~64'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Circular FIFO of {pc, instr} with two write ports, one read port and flush.
module insn_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic [1:0]               wr_cnt_i,
  input  logic [63:0]              wr0_pc_i,
  input  logic [31:0]              wr0_instr_i,
  input  logic [63:0]              wr1_pc_i,
  input  logic [31:0]              wr1_instr_i,
  input  logic                     rd_i,
  output logic                     rd_valid_o,
  output logic [63:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);

  insn_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
  logic [AW:0]    count_q, count_d;
  logic           rd_fire;

  assign rd_fire    = rd_i && (count_q != '0);
  assign wr_ptr_nxt = wr_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + (AW+1)'(wr_cnt_i) - (AW+1)'(rd_fire);
    // Flush wins over same-cycle writes and reads.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (wr_cnt_i != 2'd0) mem_q[wr_ptr_q]   <= {wr0_pc_i, wr0_instr_i};
      if (wr_cnt_i == 2'd2) mem_q[wr_ptr_nxt] <= {wr1_pc_i, wr1_instr_i};
    end
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_pc_o    = mem_q[rd_ptr_q].pc;
  assign rd_instr_o = mem_q[rd_ptr_q].instr;
  assign free_o     = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: AXI line reads split into 32-bit instructions,
// buffered with their PCs and handed to decode one per cycle.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic                  halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  req_addr_q, req_addr_d;
  logic [2:0]   beat_q, beat_d;
  logic         stopped_q, stopped_d;
  logic         drain_q, drain_d;

  logic [CW-1:0] free;
  logic          r_fire;
  logic          beat_zero;
  logic          beat_live;
  logic [63:0]   beat_pc_lo, beat_pc_hi;
  logic          keep_lo, keep_hi;
  logic [1:0]    wr_cnt;
  logic [63:0]   wr0_pc;
  logic [31:0]   wr0_instr;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = ADDR_WIDTH'(req_addr_q);
  assign m_axi_arlen   = AXI_LEN_LINE;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEF;
  assign m_axi_arprot  = 3'b000;

  assign m_axi_arvalid = (state_q == REQ);
  assign m_axi_rready  = (state_q == DATA) || (state_q == DRAIN);
  assign r_fire        = m_axi_rvalid && m_axi_rready;
  assign beat_zero     = (m_axi_rdata == '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    beat_d     = beat_q;
    stopped_d  = stopped_q;
    drain_d    = drain_q;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && !stopped_q && free >= CW'(LINE_SLOTS)) begin
          state_d    = REQ;
          req_addr_d = line_addr(fetch_pc_q);
          drain_d    = 1'b0;
        end
      end
      REQ: begin
        // The AR already offered must complete; a redirect only turns the
        // burst into one that is thrown away.
        if (m_axi_arready) begin
          beat_d  = '0;
          state_d = (drain_q || redirect_valid) ? DRAIN : DATA;
        end else if (redirect_valid) begin
          drain_d = 1'b1;
        end
      end
      DATA: begin
        if (r_fire) begin
          beat_d = beat_q + 3'd1;
          if (beat_zero) stopped_d = 1'b1;
          if (m_axi_rlast) begin
            state_d    = IDLE;
            fetch_pc_d = req_addr_q + 64'(LINE_BYTES);
          end
        end
        if (redirect_valid && !(r_fire && m_axi_rlast)) state_d = DRAIN;
      end
      DRAIN: begin
        if (r_fire && m_axi_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      stopped_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= entry;
      req_addr_q <= '0;
      beat_q     <= '0;
      stopped_q  <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      beat_q     <= beat_d;
      stopped_q  <= stopped_d;
      drain_q    <= drain_d;
    end
  end

  // Only the first line can start mid-line, so the PC filter only bites there.
  assign beat_pc_lo = req_addr_q + {58'b0, beat_q, 3'b000};
  assign beat_pc_hi = beat_pc_lo + 64'd4;
  assign beat_live  = (state_q == DATA) && r_fire && !redirect_valid &&
                      !stopped_q && !beat_zero;
  assign keep_lo    = beat_live && (beat_pc_lo >= fetch_pc_q);
  assign keep_hi    = beat_live && (beat_pc_hi >= fetch_pc_q);
  assign wr_cnt     = 2'(keep_lo) + 2'(keep_hi);
  assign wr0_pc     = keep_lo ? beat_pc_lo : beat_pc_hi;
  assign wr0_instr  = keep_lo ? m_axi_rdata[31:0] : m_axi_rdata[63:32];

  insn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .wr_cnt_i    (wr_cnt),
    .wr0_pc_i    (wr0_pc),
    .wr0_instr_i (wr0_instr),
    .wr1_pc_i    (beat_pc_hi),
    .wr1_instr_i (m_axi_rdata[63:32]),
    .rd_i        (out_ready),
    .rd_valid_o  (out_valid),
    .rd_pc_o     (out_pc),
    .rd_instr_o  (out_instr),
    .free_o      (free)
  );

  assign halted = stopped_q && !out_valid;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: AXI line responder plus scoreboards of
// expected AR addresses and expected decoded instructions.
module tb_ifetch_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = 64'h1000;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_ar[$];
  logic [63:0] line_q[$];
  int          total = 0;
  int          bad = 0;
  int          ar_budget = 0;
  int          beat_idx = 0;
  logic [63:0] zero_pc = '1;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .halted(halted)
  );

  function automatic logic [31:0] word_at(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic [63:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = pc0 + 64'(4 * i);
      e.instr = word_at(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input logic [63:0] e);
    @(posedge clk); #2;
    reset = 1'b1;
    entry = e;
    ar_budget = 0;
    redirect_valid = 1'b0;
    zero_pc = '1;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    exp_ar.delete();
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_ar.size() != 0 || line_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #2;
    total++;
    assert (n < 400) else begin
      bad++;
      $error("FAIL %s_timeout observed=%0d left expected=0", tag, exp_q.size());
    end
  endtask

  // AXI slave: accepts ARs while budget lasts, returns 8 back-to-back beats per line.
  initial begin : responder
    logic ar_hs, r_hs;
    logic [63:0] bpc;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = (m_axi_arvalid === 1'b1) && m_axi_arready;
      r_hs  = (m_axi_rready === 1'b1) && m_axi_rvalid;
      if (ar_hs) begin
        total++;
        assert (exp_ar.size() > 0) else begin
          bad++;
          $error("FAIL extra_ar observed=%h expected=none", m_axi_araddr);
        end
        if (exp_ar.size() > 0) chk("araddr", m_axi_araddr, exp_ar.pop_front());
        chk("ar_consts",
            64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                 m_axi_arlock, m_axi_arcache, m_axi_arprot}),
            64'({13'd0, 8'd7, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000}));
        chk("ar_queue_empty", 64'(out_valid), 64'd0);
        line_q.push_back(m_axi_araddr);
      end
      @(posedge clk); #1;
      if (ar_hs) ar_budget--;
      if (r_hs) begin
        if (beat_idx == 7) begin
          beat_idx = 0;
          line_q.delete(0);
        end else begin
          beat_idx++;
        end
      end
      m_axi_arready = (ar_budget > 0);
      if (line_q.size() > 0) begin
        bpc = line_q[0] + 64'(8 * beat_idx);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = (bpc == zero_pc) ? 64'd0 : {word_at(bpc + 64'd4), word_at(bpc)};
        m_axi_rlast  = (beat_idx == 7);
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rlast  = 1'b0;
      end
    end
  end

  // Decoder side: pops the instruction scoreboard on each accepted output.
  initial begin : consumer
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid && out_valid === 1'b1) begin
        if (out_ready) begin
          total++;
          assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL extra_out observed=%h expected=none", out_pc);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", 64'(out_instr), 64'(e.instr));
          end
        end else if (exp_q.size() > 0) begin
          chk("stall_pc", out_pc, exp_q[0].pc);
          chk("stall_instr", 64'(out_instr), 64'(exp_q[0].instr));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;

    // Aligned entry, one full line
    do_reset(64'h1000);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    exp_ar.push_back(64'h1000);
    expect_run(64'h1000, 16);
    ar_budget = 1;
    @(posedge clk); #2;
    chk("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("t1_araddr", m_axi_araddr, 64'h1000);
    wait_idle("t1");
    repeat (3) @(posedge clk);
    #2;
    chk("t1_next_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("t1_next_araddr", m_axi_araddr, 64'h1040);

    // Mid-line entry: 11 instructions from the first line
    do_reset(64'h1014);
    exp_ar.push_back(64'h1000);
    expect_run(64'h1014, 11);
    ar_budget = 1;
    wait_idle("t2");
    repeat (3) @(posedge clk);
    #2;
    chk("t2_next_araddr", m_axi_araddr, 64'h1040);

    // Back-pressure: full queue must not request
    do_reset(64'h1000);
    out_ready = 1'b0;
    exp_ar.push_back(64'h1000);
    expect_run(64'h1000, 16);
    ar_budget = 2;
    repeat (40) @(posedge clk);
    #2;
    chk("t3_no_ar", 64'(m_axi_arvalid), 64'd0);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_head_pc", out_pc, 64'h1000);
    exp_ar.push_back(64'h1040);
    expect_run(64'h1040, 16);
    out_ready = 1'b1;
    wait_idle("t3");

    // Redirect during beat 3
    do_reset(64'h1000);
    exp_ar.push_back(64'h1000);
    exp_ar.push_back(64'h2000);
    expect_run(64'h1000, 6);
    ar_budget = 2;
    n = 0;
    while (!(m_axi_rvalid === 1'b1 && beat_idx == 3) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    assert (n < 100) else begin
      bad++;
      $error("FAIL t4_beat3 observed=%0d cycles expected=<100", n);
    end
    exp_q.delete();
    expect_run(64'h2000, 16);
    do_redirect(64'h2000);
    chk("t4_flushed", 64'(out_valid), 64'd0);
    wait_idle("t4");
    repeat (3) @(posedge clk);
    #2;
    chk("t4_next_araddr", m_axi_araddr, 64'h2040);

    // Zero beat 5 stops fetch
    do_reset(64'h1000);
    zero_pc = 64'h1028;
    exp_ar.push_back(64'h1000);
    expect_run(64'h1000, 10);
    ar_budget = 3;
    wait_idle("t5");
    repeat (20) @(posedge clk);
    #2;
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_no_ar", 64'(m_axi_arvalid), 64'd0);

    // Redirect clears halt; second redirect while AR still pending
    ar_budget = 0;
    @(posedge clk); #2;
    exp_ar.push_back(64'h3000);
    do_redirect(64'h3000);
    chk("t6_halt_clear", 64'(halted), 64'd0);
    @(posedge clk); #2;
    chk("t6_arvalid", 64'(m_axi_arvalid), 64'd1);
    chk("t6_araddr", m_axi_araddr, 64'h3000);
    exp_ar.push_back(64'h4000);
    expect_run(64'h4008, 14);
    do_redirect(64'h4008);
    repeat (3) @(posedge clk);
    #2;
    chk("t6_ar_held_valid", 64'(m_axi_arvalid), 64'd1);
    chk("t6_ar_held_addr", m_axi_araddr, 64'h3000);
    ar_budget = 2;
    wait_idle("t6");
    repeat (3) @(posedge clk);
    #2;
    chk("t6_next_araddr", m_axi_araddr, 64'h4040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
